// File: rtl/pulse_shaper_if.sv
// Handshake bundle for pulse_shaper: request strobe in, shaped pulse and queue status out.
// The ovf/ovf_clr pair exists only when PULSE_SHAPER_OVF_EN is defined.
interface pulse_shaper_if #(
  parameter int QUEUE_W = 4
);
  logic               trig_in;
  logic               out_signal;
  logic               busy;
  logic [QUEUE_W-1:0] pending;
`ifdef PULSE_SHAPER_OVF_EN
  logic               ovf;
  logic               ovf_clr;
`endif

  modport master (
    output trig_in,
    input  out_signal,
    input  busy,
`ifdef PULSE_SHAPER_OVF_EN
    output ovf_clr,
    input  ovf,
`endif
    input  pending
  );

  modport slave (
    input  trig_in,
    output out_signal,
    output busy,
`ifdef PULSE_SHAPER_OVF_EN
    input  ovf_clr,
    output ovf,
`endif
    output pending
  );
endinterface

// File: rtl/pulse_shaper.sv
// Stretches 1-clk event strobes into pulses of HIGH_CLKS high / LOW_CLKS low minimum,
// queueing overlapping requests in a saturating counter. PULSE_SHAPER_OVF_EN adds a sticky drop flag.
module pulse_shaper #(
  parameter int HIGH_CLKS = 40,
  parameter int LOW_CLKS  = 40,
  parameter int CNT_W     = 8,
  parameter int QUEUE_W   = 4
) (
  input  logic           clk,
  input  logic           rstn,
  pulse_shaper_if.slave  bus
);

  localparam logic [1:0]         S_IDLE  = 2'd0;
  localparam logic [1:0]         S_HIGH  = 2'd1;
  localparam logic [1:0]         S_GAP   = 2'd2;
  localparam logic [QUEUE_W-1:0] Q_MAX   = '1;
  localparam logic [CNT_W-1:0]   HI_LAST = CNT_W'(HIGH_CLKS - 1);
  localparam logic [CNT_W-1:0]   LO_LAST = CNT_W'(LOW_CLKS - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_timer;
  logic [QUEUE_W-1:0] r_pend;
  logic               r_out;

  logic               w_avail;
  logic               w_consume;
  logic               w_deq;
  logic               w_enq;
  logic [QUEUE_W-1:0] w_pend_nxt;

  assign w_avail   = (r_pend != '0) || bus.trig_in;
  assign w_consume = w_avail &&
                     ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_timer == LO_LAST)));
  // Queued requests are served first; a same-cycle strobe then joins the queue.
  assign w_deq     = w_consume && (r_pend != '0);
  assign w_enq     = bus.trig_in && !(w_consume && (r_pend == '0));

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_enq && !w_deq && (r_pend != Q_MAX))
      w_pend_nxt = r_pend + 1'b1;
    else if (w_deq && !w_enq)
      w_pend_nxt = r_pend - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_out   <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_consume) begin
            r_state <= S_HIGH;
            r_out   <= 1'b1;
          end
        end
        S_HIGH: begin
          if (r_timer == HI_LAST) begin
            r_state <= S_GAP;
            r_out   <= 1'b0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_GAP: begin
          if (r_timer == LO_LAST) begin
            r_timer <= '0;
            if (w_consume) begin
              r_state <= S_HIGH;
              r_out   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_SHAPER_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = w_enq && !w_deq && (r_pend == Q_MAX);

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_ovf <= 1'b0;
    else if (w_drop)      r_ovf <= 1'b1;
    else if (bus.ovf_clr) r_ovf <= 1'b0;
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.out_signal = r_out;
  assign bus.pending    = r_pend;
  assign bus.busy       = (r_state != S_IDLE) || (r_pend != '0);

endmodule
